// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional `DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete at accept.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [1:0]      operation,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] O,
  output logic            Z,
  output logic            N
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic              is_rem_q, is_rem_d;
  logic              sgn_quo_q, sgn_quo_d;
  logic              sgn_rem_q, sgn_rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   o_q, o_d;
  logic              z_q, z_d;
  logic              n_q, n_d;

  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   res;
  logic              a_neg, b_neg;
`ifdef DIV_EARLY_OUT_EN
  logic              ovf;
  logic [XLEN-1:0]   early;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign O = o_q;
  assign Z = z_q;
  assign N = n_q;

  always_comb begin
    state_d   = state_q;
    is_rem_d  = is_rem_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    o_d       = o_q;
    z_d       = z_q;
    n_d       = n_q;
    a_neg     = ~operation[0] & A[XLEN-1];
    b_neg     = ~operation[0] & B[XLEN-1];
    // Shifted partial remainder is XLEN+1 bits; the MSB of trial is its sign.
    trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    res       = '0;
`ifdef DIV_EARLY_OUT_EN
    ovf       = ~operation[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (B == '1);
    early     = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          is_rem_d  = operation[1];
          sgn_quo_d = a_neg ^ b_neg;
          sgn_rem_d = a_neg;
          quo_d     = a_neg ? -A : A;
          dvs_d     = b_neg ? -B : B;
          rem_d     = '0;
          cnt_d     = CW'(XLEN);
          state_d   = ITER;
`ifdef DIV_EARLY_OUT_EN
          if (B == '0 || ovf) begin
            if (B == '0) early = operation[1] ? A : '1;
            else         early = operation[1] ? '0 : A;
            o_d     = early;
            z_d     = (early == '0);
            n_d     = early[XLEN-1];
            state_d = DONE;
          end
`endif
        end
      end
      ITER: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // A zero divisor yields an all-ones quotient regardless of sign.
        if (is_rem_q)        res = sgn_rem_q ? -rem_q : rem_q;
        else if (dvs_q == 0) res = '1;
        else                 res = sgn_quo_q ? -quo_q : quo_q;
        o_d     = res;
        z_d     = (res == '0);
        n_d     = res[XLEN-1];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      is_rem_q  <= 1'b0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      o_q       <= '0;
      z_q       <= 1'b1;
      n_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_rem_q  <= is_rem_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      z_q       <= z_d;
      n_q       <= n_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, monitor checks handoffs.
module tb_div_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready;
  logic [XLEN-1:0] A, B;
  logic [1:0]      operation;
  logic            in_ready, out_valid, Z, N;
  logic [XLEN-1:0] O;

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .operation(operation), .out_valid(out_valid),
    .out_ready(out_ready), .O(O), .Z(Z), .N(N)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] o;
    logic            z;
    logic            n;
    int              lat;  // edges from accept edge to first cycle with out_valid
    int              acc;  // index of the accept edge
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0, edges = 0, or_mode = 0;
  bit   seen = 0, chk_idle = 0;

  always @(posedge clk) edges++;

  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(logic [1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    exp_t e;
    logic [XLEN-1:0] q, r;
    int ia, ib;
    bit special;
    ia = a; ib = b;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (b == 0)           begin q = '1; r = a; end
    else if (special)     begin q = a;  r = '0; end
    else if (!op[0])      begin q = ia / ib; r = ia % ib; end
    else                  begin q = a / b; r = a % b; end
    e.o = op[1] ? r : q;
    e.z = (e.o == 0);
    e.n = e.o[XLEN-1];
`ifdef DIV_EARLY_OUT_EN
    e.lat = special ? 0 : XLEN + 1;
`else
    e.lat = XLEN + 1;
`endif
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compares every cycle the DUT presents a result, pops on handoff.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (chk_idle) begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk_idle = 0;
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious: out_valid with O=%h, expected no result", O);
        end else begin
          e = sb[0];
          if (!seen) begin
            chk("latency", edges - e.acc, e.lat);
            seen = 1;
          end
          chk("O", O, e.o);
          chk("Z", Z, e.z);
          chk("N", N, e.n);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
            chk_idle = 1;
          end
        end
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic issue(logic [1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    exp_t e;
    bit   rdy = 0;
    int   n = 0;
    @(posedge clk); #1;
    in_valid = 1; operation = op; A = a; B = b;
    e = model(op, a, b);
    do begin
      @(negedge clk);
      rdy   = in_ready;
      e.acc = edges + 1;
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, want 1");
    end else sb.push_back(e);
    #1;
    in_valid = 0; A = $urandom; B = $urandom; operation = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results pending, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_O"}, O, 0);
    chk({tag, "_Z"}, Z, 1);
    chk({tag, "_N"}, N, 0);
  endtask

  logic [1:0]      d_op[10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2};
  logic [XLEN-1:0] d_a[10]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234,
                                32'h1234, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
  logic [XLEN-1:0] d_b[10]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0,
                                32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

  initial begin
    int n;
    logic [XLEN-1:0] ra, rb;
    rst = 1; in_valid = 0; A = 0; B = 0; operation = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_state("reset");

    for (int i = 0; i < 10; i++) issue(d_op[i], d_a[i], d_b[i]);
    drain();

    // Backpressure: result must stay put for 10 cycles.
    or_mode = 1;
    issue(2'd2, 32'd6, 32'd3);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
    end
    or_mode = 2;
    drain();

    // Reset mid-iteration aborts the operation.
    issue(2'd1, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    seen = 0;
    @(negedge clk);
    chk_reset_state("abort");
    issue(2'd1, 32'd9, 32'd3);
    drain();

    or_mode = 0;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom;
        4:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = -$urandom_range(1, 15);
      endcase
      issue(2'($urandom), ra, rb);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
